// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA exponentiation scheduler.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH = 128;

    // Requester ids as reported on rsp_id.
    localparam logic REQ_ENC = 1'b0;
    localparam logic REQ_DEC = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } rsa_state_e;

endpackage

// File: rtl/rsa_rr_arb2.sv
// Two-requester round-robin arbiter. Grants only while enabled; on a tie the
// requester that was not granted last wins. last_q resets to 1 so bit 0 wins
// the first tie.
module rsa_rr_arb2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    // Combinational one-hot grant.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Remember the winner of each accepted transfer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/rsa_exp_scheduler.sv
// Schedules encrypt/decrypt jobs onto one shared modular-exponentiation engine,
// with round-robin arbitration, a run timeout and a valid/ready response port.
module rsa_exp_scheduler
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH   = RSA_WIDTH,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] enc_m,
    input  logic [WIDTH-1:0] enc_exp,
    input  logic [WIDTH-1:0] dec_m,
    input  logic [WIDTH-1:0] dec_exp,
    input  logic [WIDTH-1:0] key_n,
    output logic             eng_reset,
    output logic [WIDTH-1:0] eng_m,
    output logic [WIDTH-1:0] eng_e,
    output logic [WIDTH-1:0] eng_n,
    input  logic [WIDTH-1:0] eng_c,
    input  logic             eng_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    rsa_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] eng_m_q, eng_m_d;
    logic [WIDTH-1:0] eng_e_q, eng_e_d;
    logic [WIDTH-1:0] eng_n_q, eng_n_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    logic       idle;
    logic [1:0] gnt;
    logic       accept;

    assign idle   = (state_q == StIdle);
    assign accept = |(req_valid & gnt);

    rsa_rr_arb2 u_arb (
        .clk_i    (clk),
        .reset_i  (reset),
        .en_i     (idle),
        .req_i    (req_valid),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // Next-state, operand capture, run counter and response capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        eng_m_d       = eng_m_q;
        eng_e_d       = eng_e_q;
        eng_n_d       = eng_n_q;
        rsp_data_d    = rsp_data_q;
        rsp_id_d      = rsp_id_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    eng_m_d  = gnt[1] ? dec_m   : enc_m;
                    eng_e_d  = gnt[1] ? dec_exp : enc_exp;
                    eng_n_d  = key_n;
                    rsp_id_d = gnt[1] ? REQ_DEC : REQ_ENC;
                    state_d  = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + CNT_W'(1);
                // eng_ready in the first RUN cycle may be stale from the last job.
                if ((cnt_q != '0) && eng_ready) begin
                    rsp_data_d    = eng_c;
                    rsp_timeout_d = 1'b0;
                    state_d       = StDone;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any in-flight job without a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            eng_m_q       <= '0;
            eng_e_q       <= '0;
            eng_n_q       <= '0;
            rsp_data_q    <= '0;
            rsp_id_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            eng_m_q       <= eng_m_d;
            eng_e_q       <= eng_e_d;
            eng_n_q       <= eng_n_d;
            rsp_data_q    <= rsp_data_d;
            rsp_id_q      <= rsp_id_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = gnt;
    assign eng_reset   = (state_q == StIdle) || (state_q == StStart);
    assign eng_m       = eng_m_q;
    assign eng_e       = eng_e_q;
    assign eng_n       = eng_n_q;
    assign rsp_valid   = (state_q == StDone);
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = !idle;

endmodule

// File: doc/rsa_exp_scheduler.md
RSA_EXP_SCHEDULER -- requirements
Module: rsa_exp_scheduler

Interface
REQ-001 Parameter: WIDTH, 128, operand/modulus/result width in bits.
REQ-002 Parameter: TIMEOUT, 65535, maximum RUN cycles before a job is abandoned.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  in  2  per-requester job request; bit0 = encrypt, bit1 = decrypt.
REQ-006 Port: req_ready  out  2  per-requester accept; a job transfers when req_valid[i] and req_ready[i] are both high.
REQ-007 Port: enc_m, enc_exp  in  WIDTH each  encrypt base and exponent.
REQ-008 Port: dec_m, dec_exp  in  WIDTH each  decrypt base and exponent.
REQ-009 Port: key_n  in  WIDTH  shared modulus, captured at job accept.
REQ-010 Port: eng_reset  out  1  reset/start to the shared exponentiate engine.
REQ-011 Port: eng_m, eng_e, eng_n  out  WIDTH each  engine operands, held stable from accept until the next accept.
REQ-012 Port: eng_c  in  WIDTH  engine result.
REQ-013 Port: eng_ready  in  1  engine done flag.
REQ-014 Port: rsp_valid  out  1  result available.
REQ-015 Port: rsp_ready  in  1  consumer accepts the result.
REQ-016 Port: rsp_data  out  WIDTH  result; 0 when timed out.
REQ-017 Port: rsp_id  out  1  requester of the result; 0 = encrypt, 1 = decrypt.
REQ-018 Port: rsp_timeout  out  1  job abandoned at TIMEOUT.
REQ-019 Port: busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, START, RUN and DONE.
REQ-021 Grant (IDLE only, combinational):
  - sole valid requester wins;
  - with both valid, the requester not granted last wins;
  - req_ready SHALL be high only for the granted requester, and only in IDLE.
REQ-022 On accept: capture m/exp of the granted requester plus key_n into the eng_* registers; record rsp_id; update last_grant; go to START.
REQ-023 eng_reset SHALL be 1 in IDLE and START, and 0 in RUN and DONE.
REQ-024 START SHALL last exactly 1 cycle, clear the cycle counter, then go to RUN.
REQ-025 RUN counter and exit:
  - counter increments every RUN cycle;
  - eng_ready is ignored in the first RUN cycle (counter == 0);
  - from then on, eng_ready = 1 captures eng_c into rsp_data, clears rsp_timeout, and goes to DONE.
REQ-026 In RUN, if counter == TIMEOUT-1 and eng_ready = 0: rsp_data = 0, rsp_timeout = 1, go to DONE.
REQ-027 If eng_ready and the timeout coincide, eng_ready SHALL win: normal result, rsp_timeout = 0.
REQ-028 In DONE, rsp_valid = 1 and rsp_data/rsp_id/rsp_timeout SHALL stay stable until rsp_ready = 1, then go to IDLE.
REQ-029 No new job is accepted before the DONE-to-IDLE transition; the earliest next accept is the cycle after the rsp handshake.
REQ-030 Minimum accept-to-rsp_valid latency SHALL be 3 cycles (START, RUN, RUN with eng_ready) plus the engine latency.
REQ-031 Counter width SHALL be $clog2(TIMEOUT+1); it never wraps because it is cleared in START.
REQ-032 A requester dropping req_valid before accept SHALL have no effect.

Reset
REQ-033 On reset assertion, at any state including mid-RUN, the block SHALL immediately return to IDLE and set:
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_timeout = 0;
  - eng_m/e/n = 0, eng_reset = 1, counter = 0;
  - last_grant = 1, so encrypt has first priority.
REQ-034 An in-flight job SHALL be discarded silently on reset, with no response.

Structure
REQ-035 Shared package rsa_pkg SHALL hold:
  - the state enum;
  - RSA_WIDTH = 128;
  - requester id constants REQ_ENC = 0, REQ_DEC = 1.
REQ-036 Round-robin grant logic SHALL be a sub-module rsa_rr_arb2 (2 requesters; last_grant register inside).
REQ-037 The exponentiate engine SHALL be instantiated outside this block.

Verification
REQ-038 Encrypt job: m=4, e=13, n=497, real engine -> rsp_data=445, rsp_id=0, rsp_timeout=0.
REQ-039 Decrypt job: m=445, e=97, n=497 -> rsp_data=4, rsp_id=1.
REQ-040 Both req_valid held high for 4 jobs after reset -> grant order enc, dec, enc, dec; req_ready is never high for both bits at once.
REQ-041 Stub engine with eng_ready tied 0, TIMEOUT=16 -> rsp_valid 16 RUN cycles after START, rsp_timeout=1, rsp_data=0.
REQ-042 rsp_ready held 0 for 10 cycles in DONE -> outputs stable and req_ready=0 throughout; accept possible on the cycle after the handshake.
REQ-043 Reset asserted at RUN cycle 5 -> next cycle state IDLE, eng_reset=1, rsp_valid=0; a following encrypt job gets 445 normally.
